gaussian_blur_stream: RTL and testbench

// - 3x3 Gaussian smoothing stage ([1 2 1;2 4 2;1 2 1]/16) on an 8-bit greyscale raster stream.
// - Sits directly downstream of the greyscale stage inside the Canny algorithm core.
// - Pops greyscale pixels from the upstream FWFT FIFO and pushes blurred pixels into the next-stage FIFO.
// - Emits exactly one output pixel per input pixel, in raster order.

---
 rtl/canny_pkg.sv | 19 +
 rtl/line_buffer.sv | 22 ++
 rtl/gaussian_blur_stream.sv | 166 ++++++++++++++++
 tb/tb_gaussian_blur_stream.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/canny_pkg.sv
// Shared constants for the Canny core: blur kernel, stream FSM encodings, counter sizing.
// Constants only; no latency or flow control of its own.
package canny_pkg;

  localparam int unsigned KSHIFT = 4;
  localparam logic [2:0] KERNEL [3][3] = '{'{3'd1, 3'd2, 3'd1},
                                           '{3'd2, 3'd4, 3'd2},
                                           '{3'd1, 3'd2, 3'd1}};

  localparam logic [1:0] ST_FILL  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  // Counter width able to index 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One raster line of pixels: combinational read, registered write, read-before-write at one address.
// Zero-latency read; no flow control, the owner decides when to write.
module line_buffer #(
  parameter int DEPTH = 1920,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdat,
  output logic [7:0]    rdat
);

  logic [7:0] mem [0:DEPTH-1];

  assign rdat = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdat;
  end

endmodule

// File: rtl/gaussian_blur_stream.sv
// 3x3 [1 2 1;2 4 2;1 2 1]/16 blur between FWFT FIFOs, one output per input in raster order.
// Pop to out_vld is one cycle; a full downstream FIFO holds out_din and stops popping.
module gaussian_blur_stream
  import canny_pkg::*;
#(
  parameter int WIDTH  = 1920,
  parameter int HEIGHT = 1080
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_empty,
  input  logic [7:0] in_dout,
  output logic       in_rd_en,
  input  logic       out_full,
  output logic       out_wr_en,
  output logic [7:0] out_din,
  output logic       busy,
  output logic       frame_done
);

  localparam int CW = cnt_w(WIDTH);
  localparam int RW = cnt_w(HEIGHT);
  localparam int FW = cnt_w(WIDTH + 2);

  logic [1:0]    state;
  logic [CW-1:0] in_col, o_col;
  logic [RW-1:0] in_row, o_row;
  logic [FW-1:0] fill_cnt, flush_cnt;
  logic          out_vld;
  logic [7:0]    lb0_rd, lb1_rd;
  logic [7:0]    win [0:2][0:1];
  logic [7:0]    tap [0:2][0:2];
  logic [11:0]   sum;
  logic [7:0]    result;
  logic          pop, load, flush_load, last_px, at_border, frame_end;

  line_buffer #(.DEPTH(WIDTH), .AW(CW)) u_lb0 (
    .clk(clk), .we(pop), .addr(in_col), .wdat(in_dout), .rdat(lb0_rd)
  );

  line_buffer #(.DEPTH(WIDTH), .AW(CW)) u_lb1 (
    .clk(clk), .we(pop), .addr(in_col), .wdat(lb0_rd), .rdat(lb1_rd)
  );

  // Right-hand window column is the incoming pixel plus the two lines above it.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      tap[r][0] = win[r][0];
      tap[r][1] = win[r][1];
    end
    tap[0][2] = lb1_rd;
    tap[1][2] = lb0_rd;
    tap[2][2] = in_dout;
    sum = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        sum = sum + 12'(KERNEL[r][c]) * 12'(tap[r][c]);
  end

  assign at_border = (o_row == '0) || (o_row == RW'(HEIGHT - 1)) ||
                     (o_col == '0) || (o_col == CW'(WIDTH - 1));
  assign result    = at_border ? 8'd0 : sum[KSHIFT +: 8];
  assign last_px   = (in_row == RW'(HEIGHT - 1)) && (in_col == CW'(WIDTH - 1));

  assign out_wr_en  = out_vld & ~out_full;
  assign frame_end  = (state == ST_FLUSH) && (flush_cnt == FW'(WIDTH + 1));
  assign frame_done = out_wr_en & frame_end;
  assign flush_load = (state == ST_FLUSH) && (flush_cnt != FW'(WIDTH + 1)) && (~out_vld | ~out_full);
  assign load       = ((state == ST_RUN) && pop) || flush_load;
  assign busy       = (state != ST_FILL) || (fill_cnt != '0) || out_vld;

  // The final flush write may coincide with the first fill pop of the next frame.
  always_comb begin
    in_rd_en = 1'b0;
    if (rst_n && !in_empty) begin
      case (state)
        ST_FILL:  in_rd_en = 1'b1;
        ST_RUN:   in_rd_en = ~out_vld | ~out_full;
        ST_FLUSH: in_rd_en = frame_done;
        default:  in_rd_en = 1'b0;
      endcase
    end
  end
  assign pop = in_rd_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_FILL;
      fill_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        ST_FILL: begin
          if (pop) begin
            if (fill_cnt == FW'(WIDTH)) begin
              state    <= ST_RUN;
              fill_cnt <= '0;
            end else begin
              fill_cnt <= fill_cnt + FW'(1);
            end
          end
        end
        ST_RUN: begin
          if (pop && last_px) begin
            state     <= ST_FLUSH;
            flush_cnt <= '0;
          end
        end
        ST_FLUSH: begin
          if (flush_load) flush_cnt <= flush_cnt + FW'(1);
          if (frame_done) begin
            state    <= ST_FILL;
            fill_cnt <= pop ? FW'(1) : '0;
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_col <= '0;
      in_row <= '0;
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= '0;
        win[r][1] <= '0;
      end
    end else if (pop) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= tap[r][2];
      end
      if (in_col == CW'(WIDTH - 1)) begin
        in_col <= '0;
        in_row <= (in_row == RW'(HEIGHT - 1)) ? '0 : in_row + RW'(1);
      end else begin
        in_col <= in_col + CW'(1);
      end
    end
  end

  // Output coordinates advance once per loaded result, RUN or FLUSH alike.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_col   <= '0;
      o_row   <= '0;
      out_vld <= 1'b0;
      out_din <= '0;
    end else begin
      if (load) begin
        out_din <= flush_load ? 8'd0 : result;
        out_vld <= 1'b1;
        if (o_col == CW'(WIDTH - 1)) begin
          o_col <= '0;
          o_row <= (o_row == RW'(HEIGHT - 1)) ? '0 : o_row + RW'(1);
        end else begin
          o_col <= o_col + CW'(1);
        end
      end else if (out_wr_en) begin
        out_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gaussian_blur_stream.sv
// Directed + randomized checks of gaussian_blur_stream on an 8x6 raster against an arithmetic blur model.
module tb_gaussian_blur_stream;

  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_empty = 1'b1;
  logic [7:0] in_dout = 8'h00;
  logic       out_full = 1'b0;
  logic       in_rd_en, out_wr_en, busy, frame_done;
  logic [7:0] out_din;

  always #5 clk = ~clk;

  gaussian_blur_stream #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n), .in_empty(in_empty), .in_dout(in_dout),
    .in_rd_en(in_rd_en), .out_full(out_full), .out_wr_en(out_wr_en),
    .out_din(out_din), .busy(busy), .frame_done(frame_done)
  );

  int         n_assert = 0;
  int         n_fail = 0;
  logic [7:0] src_q[$];
  logic [7:0] got[$];
  int         exp_q[$];
  int         wr_cyc[$];
  int         fd_at[$];
  int         img[N];
  int         cyc = 0;
  int         pops_total = 0;
  int         busy_total = 0;
  bit         gaps = 0, bp = 0, chk_busy = 0;
  bit         last_rd = 0, prev_full = 0;
  logic [7:0] prev_din = 8'h00;

  task automatic chk(input string tag, input int obs, input int expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int blur_at(input int r, input int c);
    int s = 0;
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        s += ((dr == 0) ? 2 : 1) * ((dc == 0) ? 2 : 1) * img[(r + dr) * W + c + dc];
    return s / 16;
  endfunction

  task automatic push_frame();
    for (int i = 0; i < N; i++) src_q.push_back(8'(img[i]));
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) exp_q.push_back(blur_at(r, c));
  endtask

  task automatic clear();
    got.delete(); exp_q.delete(); wr_cyc.delete(); fd_at.delete(); src_q.delete();
    pops_total = 0; last_rd = 0; chk_busy = 0; gaps = 0; bp = 0;
  endtask

  // One clock: retire last cycle's pop, drive inputs after negedge, sample 1ns later.
  task automatic step();
    @(negedge clk);
    if (last_rd) begin
      void'(src_q.pop_front());
      pops_total++;
    end
    in_empty = (src_q.size() == 0) || (gaps && $urandom_range(0, 2) == 0);
    in_dout  = (src_q.size() != 0) ? src_q[0] : 8'h00;
    out_full = bp && cyc[0];
    #1;
    if (chk_busy) chk("busy", int'(busy), int'(pops_total > 0 && got.size() < busy_total));
    if (out_full) chk("no_write_while_full", int'(out_wr_en), 0);
    if (prev_full && !last_rd && (pops_total % N) != 0) chk("stall_hold", int'(out_din), int'(prev_din));
    if (frame_done) begin
      chk("frame_done_with_write", int'(out_wr_en), 1);
      fd_at.push_back(got.size() + 1);
    end
    if (out_wr_en) begin
      got.push_back(out_din);
      wr_cyc.push_back(cyc);
    end
    last_rd = in_rd_en; prev_full = out_full; prev_din = out_din;
    cyc++;
  endtask

  task automatic run(input int total_wr, input int budget);
    int n = 0;
    while ((got.size() < total_wr || busy) && n < budget) begin
      step();
      n++;
    end
    chk("run_within_budget", int'(n < budget), 1);
  endtask

  task automatic compare(input string name);
    chk({name, "_writes"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_px%0d", name, i), (i < got.size()) ? int'(got[i]) : -1, exp_q[i]);
  endtask

  initial begin
    // Reset state, with a non-empty upstream to prove in_rd_en is held low.
    rst_n = 1'b0; in_empty = 1'b0; in_dout = 8'hAA;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_rd_en", int'(in_rd_en), 0);
    chk("rst_out_wr_en", int'(out_wr_en), 0);
    chk("rst_out_din", int'(out_din), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    @(negedge clk);
    rst_n = 1'b1; in_empty = 1'b1;

    // Constant 100, no backpressure.
    clear();
    for (int i = 0; i < N; i++) img[i] = 100;
    push_frame();
    run(N, 1000);
    compare("const100");
    chk("const100_interior", int'(got[W + 1]), 100);
    chk("const100_fd_count", fd_at.size(), 1);
    chk("const100_fd_at", (fd_at.size() > 0) ? fd_at[0] : -1, N);
    chk("const100_steady", (wr_cyc.size() == N) ? wr_cyc[N - 1] - wr_cyc[0] : -1, N - 1);

    // Impulse of 160 at (2,3).
    clear();
    for (int i = 0; i < N; i++) img[i] = 0;
    img[2 * W + 3] = 160;
    push_frame();
    run(N, 1000);
    compare("impulse");
    chk("impulse_center", int'(got[2 * W + 3]), 40);
    chk("impulse_north", int'(got[1 * W + 3]), 20);
    chk("impulse_west", int'(got[2 * W + 2]), 20);
    chk("impulse_diag", int'(got[1 * W + 2]), 10);

    // All-255 frame: interior saturates exactly at 255.
    clear();
    for (int i = 0; i < N; i++) img[i] = 255;
    push_frame();
    run(N, 1000);
    compare("all255");
    chk("all255_interior", int'(got[3 * W + 4]), 255);
    chk("all255_border", int'(got[W - 1]), 0);

    // Constant 100 under toggling out_full and random upstream gaps.
    clear();
    for (int i = 0; i < N; i++) img[i] = 100;
    push_frame();
    bp = 1; gaps = 1;
    run(N, 4000);
    bp = 0; gaps = 0;
    compare("backpressure");

    // Reset after ~20 pops of a random frame, then a clean ramp frame.
    clear();
    for (int i = 0; i < N; i++) img[i] = $urandom_range(0, 255);
    push_frame();
    for (int i = 0; i < 200 && pops_total < 20; i++) step();
    chk("pre_reset_pops", int'(pops_total >= 20), 1);
    @(negedge clk);
    rst_n = 1'b0; in_empty = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("midrst_in_rd_en", int'(in_rd_en), 0);
      chk("midrst_out_wr_en", int'(out_wr_en), 0);
      chk("midrst_out_din", int'(out_din), 0);
      chk("midrst_busy", int'(busy), 0);
      @(negedge clk);
    end
    rst_n = 1'b1; in_empty = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("postrst_out_wr_en", int'(out_wr_en), 0);
      chk("postrst_out_din", int'(out_din), 0);
      chk("postrst_busy", int'(busy), 0);
      @(negedge clk);
    end
    clear();
    for (int i = 0; i < N; i++) img[i] = i;
    push_frame();
    run(N, 1000);
    compare("ramp");

    // Two random frames back to back, upstream never empty.
    clear();
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < N; i++) img[i] = $urandom_range(0, 255);
      push_frame();
    end
    chk_busy = 1; busy_total = 2 * N;
    run(2 * N, 2000);
    chk_busy = 0;
    compare("b2b");
    chk("b2b_fd_count", fd_at.size(), 2);
    chk("b2b_fd_first", (fd_at.size() > 0) ? fd_at[0] : -1, N);
    chk("b2b_fd_second", (fd_at.size() > 1) ? fd_at[1] : -1, 2 * N);
    chk("b2b_busy_end", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
